// File: rtl/dds_spi_slave.sv
// DDS SPI register responder: oversamples SCLK/CS/SDIO/SYNCIO/IO_UPDATE and decodes writes into shadow/active banks.
// Latency: 3 clk from pin to event, wr_stb/upd_stb 4 clk after the pin edge, rd_data combinational.
// Backpressure: none; SDO readback is built only when DDS_SPI_READBACK_EN is defined.
module dds_spi_slave #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SCLK,
    input  logic          CS,
    input  logic          SDIO,
    input  logic          SYNCIO,
    input  logic          IO_UPDATE,
    output logic          SDO,
    input  logic [AW-1:0] rd_sel,
    output logic [31:0]   rd_data,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic          upd_stb,
    output logic          err_stb
);
    typedef enum logic {IDLE, DATA} state_t;

    // Pin order {IO_UPDATE, SYNCIO, SDIO, CS, SCLK}. Reset levels keep reset release from faking
    // an IO_UPDATE/SCLK rise or a CS fall when those pins are already active.
    localparam logic [4:0] PIN_RST = 5'b10001;

    logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d;
    logic          sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic          cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;
    logic          upd_rise_q, upd_rise_d;
    logic          cs_lo, sdio_s, syncio_hi;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          rnw_q, rnw_d;
    logic          armed_q, armed_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          wr_stb_q, wr_stb_d;
    logic          upd_stb_q, upd_stb_d;
    logic          err_stb_q, err_stb_d;
    logic [31:0]   shadow_q [NREG];
    logic [31:0]   shadow_d [NREG];
    logic [31:0]   active_q [NREG];
    logic [31:0]   active_d [NREG];

    logic [7:0]    new_byte;
    logic [31:0]   new_word;
    logic          addr_ok;
    logic          unused_sig;

`ifdef DDS_SPI_READBACK_EN
    logic [31:0]   rd_sh_q, rd_sh_d;
    logic          sdo_q, sdo_d;
    logic [31:0]   rd_word;
`endif

    always_comb begin
        sync1_d     = {IO_UPDATE, SYNCIO, SDIO, CS, SCLK};
        sync2_d     = sync1_q;
        lvl_d       = sync2_q;
        sclk_rise_d =  sync2_q[0] & ~lvl_q[0];
        sclk_fall_d = ~sync2_q[0] &  lvl_q[0];
        cs_rise_d   =  sync2_q[1] & ~lvl_q[1];
        cs_fall_d   = ~sync2_q[1] &  lvl_q[1];
        upd_rise_d  =  sync2_q[4] & ~lvl_q[4];
    end

    // Levels come from the edge register so they line up with the registered event flags.
    assign cs_lo     = ~lvl_q[1];
    assign sdio_s    = lvl_q[2];
    assign syncio_hi = lvl_q[3];

    assign new_byte = {shreg_q[6:0], sdio_s};
    assign new_word = {wdata_q[23:0], new_byte};
    assign addr_ok  = (32'(addr_q) < 32'(NREG));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        rnw_d      = rnw_q;
        armed_d    = armed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_addr_d  = wr_addr_q;
        wr_stb_d   = 1'b0;
        upd_stb_d  = 1'b0;
        err_stb_d  = 1'b0;
        shadow_d   = shadow_q;
        active_d   = active_q;
`ifdef DDS_SPI_READBACK_EN
        rd_sh_d    = rd_sh_q;
        sdo_d      = sdo_q;
        rd_word    = (32'(new_byte[4:0]) < 32'(NREG)) ? active_q[new_byte[AW-1:0]] : 32'd0;
`endif

        // Bits are only accepted once a CS fall has been seen since reset.
        if (cs_fall_q) begin
            armed_d = 1'b1;
        end

        if (syncio_hi) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            shreg_d    = 8'd0;
`ifdef DDS_SPI_READBACK_EN
            sdo_d      = 1'b0;
`endif
        end else if (cs_rise_q) begin
            if (bit_cnt_q != 3'd0) begin
                err_stb_d = 1'b1;
                bit_cnt_d = 3'd0;
            end
        end else if (sclk_rise_q && cs_lo && armed_q) begin
            shreg_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef DDS_SPI_READBACK_EN
            if (state_q == DATA && rnw_q) begin
                rd_sh_d = {rd_sh_q[30:0], 1'b0};
            end
`endif
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    IDLE: begin
                        rnw_d      = new_byte[7];
                        addr_d     = new_byte[4:0];
                        state_d    = DATA;
                        byte_cnt_d = 3'd1;
`ifdef DDS_SPI_READBACK_EN
                        if (new_byte[7]) begin
                            rd_sh_d = rd_word;
                            sdo_d   = rd_word[31];
                        end
`endif
                    end
                    DATA: begin
                        wdata_d = new_word;
                        if (byte_cnt_q == 3'd4) begin
                            state_d    = IDLE;
                            byte_cnt_d = 3'd0;
`ifdef DDS_SPI_READBACK_EN
                            sdo_d      = 1'b0;
`endif
                            if (!rnw_q) begin
                                if (addr_ok) begin
                                    shadow_d[addr_q[AW-1:0]] = new_word;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = addr_q[AW-1:0];
                                end else begin
                                    err_stb_d = 1'b1;
                                end
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
`ifdef DDS_SPI_READBACK_EN
        end else if (sclk_fall_q && cs_lo && state_q == DATA && rnw_q) begin
            sdo_d = rd_sh_q[31];
`endif
        end

        // Copy from shadow_d so a commit landing in the same clk reaches the active bank.
        if (upd_rise_q) begin
            active_d  = shadow_d;
            upd_stb_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= PIN_RST;
            sync2_q     <= PIN_RST;
            lvl_q       <= PIN_RST;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            upd_rise_q  <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 3'd0;
            shreg_q     <= 8'd0;
            rnw_q       <= 1'b0;
            armed_q     <= 1'b0;
            addr_q      <= 5'd0;
            wdata_q     <= 32'd0;
            wr_addr_q   <= '0;
            wr_stb_q    <= 1'b0;
            upd_stb_q   <= 1'b0;
            err_stb_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= 32'd0;
                active_q[i] <= 32'd0;
            end
`ifdef DDS_SPI_READBACK_EN
            rd_sh_q     <= 32'd0;
            sdo_q       <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            lvl_q       <= lvl_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            upd_rise_q  <= upd_rise_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            rnw_q       <= rnw_d;
            armed_q     <= armed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_addr_q   <= wr_addr_d;
            wr_stb_q    <= wr_stb_d;
            upd_stb_q   <= upd_stb_d;
            err_stb_q   <= err_stb_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
`ifdef DDS_SPI_READBACK_EN
            rd_sh_q     <= rd_sh_d;
            sdo_q       <= sdo_d;
`endif
        end
    end

`ifdef DDS_SPI_READBACK_EN
    assign SDO        = sdo_q;
    assign unused_sig = ^{lvl_q[0], lvl_q[4], shreg_q[7]};
`else
    assign SDO        = 1'b0;
    assign unused_sig = ^{lvl_q[0], lvl_q[4], shreg_q[7], sclk_fall_q};
`endif

    assign rd_data = active_q[rd_sel];
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign upd_stb = upd_stb_q;
    assign err_stb = err_stb_q;

endmodule

// File: tb/tb_dds_spi_slave.sv
// Bench for dds_spi_slave: table of register transactions, corner-case sequences and random traffic
// checked against an array-level model of the shadow/active banks.
`timescale 1ns/1ps
module tb_dds_spi_slave;
    localparam int NREG = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        SCLK, CS, SDIO, SYNCIO, IO_UPDATE;
    logic        SDO;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        wr_stb, upd_stb, err_stb;
    logic [2:0]  wr_addr;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, upd_cnt = 0, err_cnt = 0, sdo_hi_cnt = 0;
    logic        last_wr_upd = 1'b0;
    logic [31:0] last_wr_rd = 32'd0;

    logic [31:0] shadow_m [NREG];
    logic [31:0] active_m [NREG];

    typedef struct {
        bit          rnw;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          upd;
        int          exp_wr;
        int          exp_err;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    dds_spi_slave #(.NREG(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .SDIO(SDIO), .SYNCIO(SYNCIO),
        .IO_UPDATE(IO_UPDATE), .SDO(SDO), .rd_sel(rd_sel), .rd_data(rd_data),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .upd_stb(upd_stb), .err_stb(err_stb)
    );

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            wr_cnt++;
            last_wr_upd = upd_stb;
            last_wr_rd  = rd_data;
        end
        if (upd_stb === 1'b1) upd_cnt++;
        if (err_stb === 1'b1) err_cnt++;
        if (SDO !== 1'b0) sdo_hi_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            shadow_m[i] = 32'd0;
            active_m[i] = 32'd0;
        end
    endtask

    task automatic model_write(input bit rnw, input logic [4:0] addr, input logic [31:0] data);
        if (!rnw && int'(addr) < NREG) shadow_m[addr[2:0]] = data;
    endtask

    task automatic model_update();
        for (int i = 0; i < NREG; i++) active_m[i] = shadow_m[i];
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NREG; i++) begin
            rd_sel = 3'(i);
            #1;
            check(name, rd_data, active_m[i]);
        end
        rd_sel = 3'd0;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit upd_last,
                            output logic [7:0] sdo_b);
        sdo_b = 8'd0;
        for (int i = 7; i > 7 - nbits; i--) begin
            SDIO = b[i];
            wait_clk(6);
            sdo_b[i] = SDO;
            SCLK = 1'b1;
            if (upd_last && i == 0) IO_UPDATE = 1'b1;
            wait_clk(6);
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, input bit upd_last, output logic [7:0] sdo_b);
        CS = 1'b0;
        wait_clk(6);
        spi_bits(b, 8, upd_last, sdo_b);
        wait_clk(6);
        CS = 1'b1;
        IO_UPDATE = 1'b0;
        wait_clk(6);
    endtask

    task automatic spi_txn(input bit rnw, input logic [4:0] addr, input logic [31:0] data,
                           input bit upd_last, output logic [31:0] sdo_w);
        logic [7:0] sb;
        spi_byte({rnw, 2'b00, addr}, 1'b0, sb);
        sdo_w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            spi_byte(data[31-8*k -: 8], upd_last && (k == 3), sb);
            sdo_w = {sdo_w[23:0], sb};
        end
    endtask

    task automatic run_txn(input bit rnw, input logic [4:0] addr, input logic [31:0] data,
                           input int exp_wr, input int exp_err);
        int w0, e0, s0;
        logic [31:0] sw, exp_rd;
        w0 = wr_cnt; e0 = err_cnt; s0 = sdo_hi_cnt;
        exp_rd = (int'(addr) < NREG) ? active_m[addr[2:0]] : 32'd0;
        spi_txn(rnw, addr, data, 1'b0, sw);
        model_write(rnw, addr, data);
        check("wr_stb_count", wr_cnt - w0, exp_wr);
        check("err_stb_count", err_cnt - e0, exp_err);
        if (exp_wr != 0) check("wr_addr", {29'd0, wr_addr}, {29'd0, addr[2:0]});
        if (rnw) begin
`ifdef DDS_SPI_READBACK_EN
            check("sdo_readback", sw, exp_rd);
`else
            check("sdo_tied_low", sdo_hi_cnt - s0, 0);
`endif
        end
        check("sdo_idle", {31'd0, SDO}, 32'd0);
    endtask

    task automatic pulse_update();
        int n, u0;
        u0 = upd_cnt;
        IO_UPDATE = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (upd_stb === 1'b1) break;
        end
        check("upd_latency", n, 4);
        wait_clk(2);
        IO_UPDATE = 1'b0;
        wait_clk(6);
        check("upd_stb_count", upd_cnt - u0, 1);
        model_update();
    endtask

    initial begin
        logic [7:0]  sb;
        logic [31:0] sw;
        int w0, e0, u0;
        bit rnw;
        logic [4:0] addr;
        logic [31:0] data;

        vecs[0] = '{1'b0, 5'h02, 32'h12345678, 1'b1, 1, 0};
        vecs[1] = '{1'b0, 5'h1F, 32'hCAFEF00D, 1'b1, 0, 1};
        vecs[2] = '{1'b0, 5'h07, 32'h0BADF00D, 1'b0, 1, 0};
        vecs[3] = '{1'b1, 5'h02, 32'h00000000, 1'b0, 0, 0};
        vecs[4] = '{1'b0, 5'h05, 32'hFFFFFFFF, 1'b1, 1, 0};
        vecs[5] = '{1'b1, 5'h09, 32'h00000000, 1'b0, 0, 0};

        rst = 1'b1; SCLK = 1'b0; CS = 1'b1; SDIO = 1'b0; SYNCIO = 1'b0; IO_UPDATE = 1'b0;
        rd_sel = 3'd0;
        model_reset();
        wait_clk(5);
        rst = 1'b0;
        check("rst_sdo", {31'd0, SDO}, 32'd0);
        check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
        check("rst_upd_stb", {31'd0, upd_stb}, 32'd0);
        check("rst_err_stb", {31'd0, err_stb}, 32'd0);
        check("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
        check_regs("rst_rd_data");
        wait_clk(8);

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].rnw, vecs[v].addr, vecs[v].data, vecs[v].exp_wr, vecs[v].exp_err);
            check_regs("rd_pre_update");
            if (vecs[v].upd) begin
                pulse_update();
                check_regs("rd_post_update");
            end
        end

        // Partial byte aborted by CS, then a clean write.
        e0 = err_cnt; w0 = wr_cnt;
        CS = 1'b0;
        wait_clk(6);
        spi_bits(8'hE0, 3, 1'b0, sb);
        wait_clk(6);
        CS = 1'b1;
        wait_clk(6);
        check("partial_err", err_cnt - e0, 1);
        check("partial_no_wr", wr_cnt - w0, 0);
        run_txn(1'b0, 5'h01, 32'hA5A5A5A5, 1, 0);
        pulse_update();
        check_regs("partial_then_write");

        // SYNCIO abort after two data bytes.
        spi_byte(8'h06, 1'b0, sb);
        spi_byte(8'h11, 1'b0, sb);
        spi_byte(8'h22, 1'b0, sb);
        SYNCIO = 1'b1;
        wait_clk(6);
        SYNCIO = 1'b0;
        wait_clk(6);
        run_txn(1'b0, 5'h03, 32'h0000FFFF, 1, 0);
        pulse_update();
        check_regs("syncio_then_write");

        // IO_UPDATE coinciding with the commit.
        rd_sel = 3'd0;
        w0 = wr_cnt; u0 = upd_cnt;
        spi_txn(1'b0, 5'h00, 32'hDEADBEEF, 1'b1, sw);
        model_write(1'b0, 5'h00, 32'hDEADBEEF);
        model_update();
        check("coinc_wr_count", wr_cnt - w0, 1);
        check("coinc_upd_count", upd_cnt - u0, 1);
        check("coinc_upd_with_wr", {31'd0, last_wr_upd}, 32'd1);
        check("coinc_active0", last_wr_rd, 32'hDEADBEEF);
        check_regs("coinc_regs");

        // Reset in the middle of a frame with CS held low.
        e0 = err_cnt;
        CS = 1'b0;
        wait_clk(6);
        spi_bits(8'h82, 4, 1'b0, sb);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        model_reset();
        wait_clk(1);
        check("midrst_wr_addr", {29'd0, wr_addr}, 32'd0);
        check_regs("midrst_regs");
        wait_clk(6);
        w0 = wr_cnt;
        spi_bits(8'h2F, 4, 1'b0, sb);
        spi_bits(8'h04, 8, 1'b0, sb);
        wait_clk(6);
        CS = 1'b1;
        wait_clk(6);
        check("midrst_ignored_err", err_cnt - e0, 0);
        check("midrst_ignored_wr", wr_cnt - w0, 0);
        run_txn(1'b0, 5'h04, 32'h600DCAFE, 1, 0);
        pulse_update();
        check_regs("midrst_then_write");

        for (int t = 0; t < 16; t++) begin
            rnw  = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            data = $urandom;
            run_txn(rnw, addr, data,
                    (!rnw && int'(addr) < NREG) ? 1 : 0,
                    (!rnw && int'(addr) >= NREG) ? 1 : 0);
            if ($urandom_range(0, 1) == 1) begin
                pulse_update();
                check_regs("rand_post_update");
            end else begin
                check_regs("rand_pre_update");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
